bcd_7seg_scan: RTL and testbench

//  Downstream display stage for the mod-10 counter chain. Captures NUM_DIGITS packed BCD digits
//  and time-multiplexes them onto one common-segment 7-segment display.
//  - One digit is enabled at a time, at a fixed refresh rate.
//  - One blank cycle is inserted at every digit switch to prevent ghosting.
//  - Emits a one-cycle frame tick each time the full scan completes.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/bcd_to_7seg.sv | 14 +
 rtl/bcd_7seg_scan.sv | 99 +++++++++
 tb/tb_bcd_7seg_scan.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: BCD digit type, blank pattern and the
// {g,f,e,d,c,b,a} active-high decode table for digits 0..9.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; codes 10..15 render blank.
module bcd_to_7seg
  import seg7_pkg::*;
(
  input  bcd_t        i_bcd,
  output logic [6:0]  o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_bcd <= 4'd9) o_seg = SEG_DIGIT[i_bcd];
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Multiplexed 7-segment scanner with snapshot capture, inter-digit blank cycle
// and frame tick. Define LEADING_ZERO_BLANK_EN to suppress leading zeros.
module bcd_7seg_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int P_W   = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [P_W-1:0]   P_LAST   = P_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [P_W-1:0]          r_p;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_tick;

  bcd_t                  w_digit;
  logic [6:0]            w_dec;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic                  w_blank_sel;
  logic                  w_wrap;

  assign w_wrap = (r_p == P_LAST);

  // Equality-based selection keeps the mux legal for non-power-of-two digit counts.
  always_comb begin
    w_digit     = '0;
    w_onehot    = '0;
    w_blank_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_digit     = r_snap[4*i +: 4];
        w_onehot[i] = 1'b1;
        w_blank_sel = w_lz_mask[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i>0 is a leading zero when it and every more significant digit are zero.
  always_comb begin
    w_lz_mask = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      w_lz_mask[i] = 1'b1;
      for (int unsigned j = i; j < NUM_DIGITS; j++) begin
        if (r_snap[4*j +: 4] != 4'd0) w_lz_mask[i] = 1'b0;
      end
    end
  end
`else
  assign w_lz_mask = '0;
`endif

  bcd_to_7seg u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_snap <= '0;
      r_idx  <= '0;
      r_p    <= '0;
      r_seg  <= '0;
      r_an   <= '0;
      r_tick <= 1'b0;
    end else begin
      if (load) r_snap <= bcd_in;
      if (w_wrap) begin
        r_p   <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_p <= r_p + 1'b1;
      end
      r_an   <= w_wrap ? '0 : w_onehot;
      r_seg  <= (w_wrap || w_blank_sel) ? SEG_BLANK : w_dec;
      r_tick <= w_wrap && (r_idx == IDX_LAST);
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Scoreboard bench for bcd_7seg_scan (NUM_DIGITS=4, REFRESH_DIV=4); expectations
// follow LEADING_ZERO_BLANK_EN when defined.
module tb_bcd_7seg_scan;

  localparam int ND = 4;
  localparam int RD = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZLEAD = 7'h00;
`else
  localparam logic [6:0] ZLEAD = 7'h3F;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  bcd_7seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .clr        (clr),
    .bcd_in     (bcd_in),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       tick;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void push(logic [3:0] a, logic [6:0] s, logic t);
    sb.push_back({a, s, t});
  endfunction

  function automatic void push_slot(int idx, logic [6:0] s, int nvis, logic t);
    for (int i = 0; i < nvis; i++) push(4'b0001 << idx, s, 1'b0);
    push(4'b0000, 7'h00, t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    clr = 1'b1; load = 1'b0;
    step();
    clr = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    clr = 1'b1; load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({an, seg, frame_tick} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset edge %0d: got an=%b seg=%h tick=%b, expected all zero", k, an, seg, frame_tick);
      end
    end
    clr = 1'b0;
    push_slot(0, 7'h3F, 3, 1'b0);
    push_slot(1, ZLEAD, 3, 1'b0);
    push_slot(2, ZLEAD, 3, 1'b0);
    push_slot(3, ZLEAD, 3, 1'b1);
    for (int k = 0; k < 16; k++) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, frame_tick} !== e) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                 k, an, seg, frame_tick, e.an, e.seg, e.tick);
      end
    end
  endtask

  task automatic test_scan();
    reset_dut();
    push(4'b0001, 7'h3F, 1'b0);
    push_slot(0, 7'h66, 2, 1'b0);
    push_slot(1, 7'h4F, 3, 1'b0);
    push_slot(2, 7'h5B, 3, 1'b0);
    push_slot(3, 7'h06, 3, 1'b1);
    push_slot(0, 7'h66, 3, 1'b0);
    push_slot(1, 7'h4F, 3, 1'b0);
    push_slot(2, 7'h5B, 3, 1'b0);
    push_slot(3, 7'h06, 3, 1'b1);
    bcd_in = 16'h1234;
    for (int k = 0; k < 32; k++) begin
      load = (k == 0);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, frame_tick} !== e) begin
        n_fail++;
        $display("FAIL scan edge %0d: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                 k, an, seg, frame_tick, e.an, e.seg, e.tick);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_invalid();
    reset_dut();
    push(4'b0001, 7'h3F, 1'b0);
    push_slot(0, 7'h3F, 2, 1'b0);
    push_slot(1, 7'h00, 3, 1'b0);
    push_slot(2, 7'h6F, 3, 1'b0);
    push_slot(3, 7'h00, 3, 1'b1);
    bcd_in = 16'hA9F0;
    for (int k = 0; k < 16; k++) begin
      load = (k == 0);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, frame_tick} !== e) begin
        n_fail++;
        $display("FAIL invalid edge %0d: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                 k, an, seg, frame_tick, e.an, e.seg, e.tick);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_wrap_load();
    reset_dut();
    push(4'b0001, 7'h3F, 1'b0);
    push_slot(0, 7'h6D, 2, 1'b0);
    push_slot(1, 7'h6D, 3, 1'b0);
    push_slot(2, 7'h6D, 3, 1'b0);
    push_slot(3, 7'h6D, 3, 1'b1);
    push_slot(0, 7'h7F, 3, 1'b0);
    push_slot(1, ZLEAD, 3, 1'b0);
    for (int k = 0; k < 24; k++) begin
      load   = (k == 0) || (k == 15);
      bcd_in = (k == 15) ? 16'h0008 : 16'h5555;
      step();
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, frame_tick} !== e) begin
        n_fail++;
        $display("FAIL wrap_load edge %0d: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                 k, an, seg, frame_tick, e.an, e.seg, e.tick);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_mid_reset();
    reset_dut();
    push(4'b0001, 7'h3F, 1'b0);
    push_slot(0, 7'h66, 2, 1'b0);
    push_slot(1, 7'h4F, 3, 1'b0);
    push(4'b0100, 7'h5B, 1'b0);
    push(4'b0000, 7'h00, 1'b0);
    push_slot(0, 7'h3F, 3, 1'b0);
    push(4'b0010, ZLEAD, 1'b0);
    bcd_in = 16'h1234;
    for (int k = 0; k < 15; k++) begin
      load = (k == 0);
      clr  = (k == 9);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, frame_tick} !== e) begin
        n_fail++;
        $display("FAIL mid_reset edge %0d: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                 k, an, seg, frame_tick, e.an, e.seg, e.tick);
      end
    end
    clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_leading_zero();
    reset_dut();
    push(4'b0001, 7'h3F, 1'b0);
    push_slot(0, 7'h3F, 2, 1'b0);
    push_slot(1, 7'h07, 3, 1'b0);
    push_slot(2, ZLEAD, 3, 1'b0);
    push_slot(3, ZLEAD, 3, 1'b1);
    bcd_in = 16'h0070;
    for (int k = 0; k < 16; k++) begin
      load = (k == 0);
      step();
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, frame_tick} !== e) begin
        n_fail++;
        $display("FAIL leading_zero edge %0d: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                 k, an, seg, frame_tick, e.an, e.seg, e.tick);
      end
    end
    load = 1'b0;
  endtask

  // load held high: each edge's capture shows on the next edge, including across the blank
  task automatic test_back_to_back();
    reset_dut();
    push(4'b0001, 7'h3F, 1'b0);
    push(4'b0001, 7'h06, 1'b0);
    push(4'b0001, 7'h5B, 1'b0);
    push(4'b0000, 7'h00, 1'b0);
    push(4'b0010, 7'h66, 1'b0);
    push(4'b0010, 7'h6D, 1'b0);
    push(4'b0010, 7'h7D, 1'b0);
    push(4'b0000, 7'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] nib;
      nib    = 4'(k + 1);
      load   = 1'b1;
      bcd_in = {4{nib}};
      step();
      e = sb.pop_front();
      n_checks++;
      if ({an, seg, frame_tick} !== e) begin
        n_fail++;
        $display("FAIL back_to_back edge %0d: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
                 k, an, seg, frame_tick, e.an, e.seg, e.tick);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_invalid();
    test_wrap_load();
    test_mid_reset();
    test_leading_zero();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
